// File: rtl/wr_pkg.sv
// Shared write-strobe constants: register codes and the strobe/code widths used by
// both the write-enable decoder and the strobe encoder.
package wr_pkg;

   localparam int STROBE_W = 20;
   localparam int CODE_W   = 5;

   localparam logic [CODE_W-1:0] REG_R1   = 5'd1;
   localparam logic [CODE_W-1:0] REG_R2   = 5'd2;
   localparam logic [CODE_W-1:0] REG_R3   = 5'd3;
   localparam logic [CODE_W-1:0] REG_R4   = 5'd4;
   localparam logic [CODE_W-1:0] REG_R5   = 5'd5;
   localparam logic [CODE_W-1:0] REG_R6   = 5'd6;
   localparam logic [CODE_W-1:0] REG_R7   = 5'd7;
   localparam logic [CODE_W-1:0] REG_R8   = 5'd8;
   localparam logic [CODE_W-1:0] REG_R9   = 5'd9;
   localparam logic [CODE_W-1:0] REG_R10  = 5'd10;
   localparam logic [CODE_W-1:0] REG_R11  = 5'd11;
   localparam logic [CODE_W-1:0] REG_R12  = 5'd12;
   localparam logic [CODE_W-1:0] REG_R13  = 5'd13;
   localparam logic [CODE_W-1:0] REG_R14  = 5'd14;
   localparam logic [CODE_W-1:0] REG_PC   = 5'd15;
   localparam logic [CODE_W-1:0] REG_TOTR = 5'd16;
   localparam logic [CODE_W-1:0] REG_MDDR = 5'd17;
   localparam logic [CODE_W-1:0] REG_TR   = 5'd18;
   localparam logic [CODE_W-1:0] REG_AR   = 5'd21;
   localparam logic [CODE_W-1:0] REG_IR   = 5'd22;
   localparam logic [CODE_W-1:0] REG_ALL  = 5'd31;

   // Strobe bits 0..17 map straight to codes 1..18; the top two bits jump to AR/IR.
   function automatic logic [CODE_W-1:0] bit_code(input int k);
      logic [CODE_W-1:0] c;
      if (k == STROBE_W - 2)
         c = REG_AR;
      else if (k == STROBE_W - 1)
         c = REG_IR;
      else
         c = CODE_W'(k + 1);
      return c;
   endfunction

endpackage

// File: rtl/wr_trace_fifo.sv
// First-word-fall-through trace FIFO with occupancy count and sticky overflow flag.
// When empty the head outputs keep showing the most recently popped entry.
module wr_trace_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int CW    = 5
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     push,
   input  logic [CW+DW-1:0]         push_data,
   input  logic                     pop_ready,
   input  logic                     ovf_clr,
   output logic                     head_valid,
   output logic [CW+DW-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [CW+DW-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign head_valid = (count != '0);
   assign full       = (count == CNTW'(DEPTH));
   assign do_pop     = head_valid && pop_ready;
   assign do_push    = push && (!full || do_pop);
   assign head_data  = head_valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CNTW'(1);
         else if (do_pop && !do_push)
            count <= count - CNTW'(1);
         if (ovf_clr)
            ovf <= 1'b0;
         else if (push && full && !do_pop)
            ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/wr_strobe_encoder.sv
// Re-encodes the one-hot write strobe into a register code, flags multi-hot vectors and
// logs qualified writes into a trace FIFO. WRENC_ERRCNT_EN adds the illegal-vector counter.
module wr_strobe_encoder
   import wr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int ECW   = 8
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic [STROBE_W-1:0]      WRDec_in,
   input  logic                     Wr_en,
   input  logic [DW-1:0]            Bus_in,
   output logic                     Enc_valid,
   output logic [CODE_W-1:0]        Enc_code,
   output logic                     Enc_err,
   output logic                     Trc_valid,
   input  logic                     Trc_ready,
   output logic [CODE_W-1:0]        Trc_code,
   output logic [DW-1:0]            Trc_data,
   output logic [$clog2(DEPTH):0]   Trc_count,
   output logic                     Trc_ovf,
   input  logic                     Ovf_clr,
   output logic [ECW-1:0]           Err_count
);

   logic [CODE_W-1:0]    code_c;
   logic                 legal_c;
   logic                 err_c;
   logic [CODE_W+DW-1:0] head;

   always_comb begin
      code_c  = '0;
      legal_c = 1'b0;
      err_c   = 1'b0;
      if (WRDec_in == '1) begin
         code_c  = REG_ALL;
         legal_c = 1'b1;
      end else if (WRDec_in != '0) begin
         // A single set bit survives clearing its lowest set bit as zero.
         if ((WRDec_in & (WRDec_in - STROBE_W'(1))) == '0) begin
            legal_c = 1'b1;
            for (int k = 0; k < STROBE_W; k++)
               if (WRDec_in[k]) code_c = bit_code(k);
         end else begin
            err_c = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Enc_valid <= 1'b0;
         Enc_code  <= '0;
         Enc_err   <= 1'b0;
      end else begin
         Enc_valid <= legal_c;
         Enc_code  <= code_c;
         Enc_err   <= err_c;
      end
   end

   wr_trace_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .CW    (CODE_W)
   ) u_trace_fifo (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .push       (Wr_en && legal_c),
      .push_data  ({code_c, Bus_in}),
      .pop_ready  (Trc_ready),
      .ovf_clr    (Ovf_clr),
      .head_valid (Trc_valid),
      .head_data  (head),
      .count      (Trc_count),
      .ovf        (Trc_ovf)
   );

   assign Trc_code = head[CODE_W+DW-1:DW];
   assign Trc_data = head[DW-1:0];

`ifdef WRENC_ERRCNT_EN
   logic [ECW-1:0] err_cnt;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
         err_cnt <= '0;
      else if (Ovf_clr)
         err_cnt <= '0;
      else if (Wr_en && err_c && (err_cnt != '1))
         err_cnt <= err_cnt + ECW'(1);
   end

   assign Err_count = err_cnt;
`else
   assign Err_count = '0;
`endif

endmodule

// File: tb/tb_wr_strobe_encoder.sv
// Directed bench for wr_strobe_encoder: table-driven encode sweep plus FIFO corner sequences.
module tb_wr_strobe_encoder;

   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int ECW   = 8;

   logic          Clock = 1'b0;
   logic          Reset_n;
   logic [19:0]   WRDec_in;
   logic          Wr_en;
   logic [DW-1:0] Bus_in;
   logic          Enc_valid;
   logic [4:0]    Enc_code;
   logic          Enc_err;
   logic          Trc_valid;
   logic          Trc_ready;
   logic [4:0]    Trc_code;
   logic [DW-1:0] Trc_data;
   logic [2:0]    Trc_count;
   logic          Trc_ovf;
   logic          Ovf_clr;
   logic [ECW-1:0] Err_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clock = ~Clock;

   wr_strobe_encoder #(.DEPTH(DEPTH), .DW(DW), .ECW(ECW)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .WRDec_in  (WRDec_in),
      .Wr_en     (Wr_en),
      .Bus_in    (Bus_in),
      .Enc_valid (Enc_valid),
      .Enc_code  (Enc_code),
      .Enc_err   (Enc_err),
      .Trc_valid (Trc_valid),
      .Trc_ready (Trc_ready),
      .Trc_code  (Trc_code),
      .Trc_data  (Trc_data),
      .Trc_count (Trc_count),
      .Trc_ovf   (Trc_ovf),
      .Ovf_clr   (Ovf_clr),
      .Err_count (Err_count)
   );

   typedef struct {
      logic [19:0] dec;
      logic [4:0]  code;
      logic        valid;
      logic        err;
   } enc_vec_t;

   enc_vec_t vecs [24];

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_one(input logic [19:0] dec, input logic [DW-1:0] data);
      WRDec_in = dec;
      Bus_in   = data;
      Wr_en    = 1'b1;
      tick();
      Wr_en    = 1'b0;
      WRDec_in = '0;
   endtask

   logic [ECW-1:0] exp_err;
   logic [4:0]     exp_codes [4];

   initial begin
      for (int k = 0; k < 18; k++)
         vecs[k] = '{dec: 20'(1) << k, code: 5'(k + 1), valid: 1'b1, err: 1'b0};
      vecs[18] = '{dec: 20'h40000, code: 5'd21, valid: 1'b1, err: 1'b0};
      vecs[19] = '{dec: 20'h80000, code: 5'd22, valid: 1'b1, err: 1'b0};
      vecs[20] = '{dec: 20'hFFFFF, code: 5'd31, valid: 1'b1, err: 1'b0};
      vecs[21] = '{dec: 20'h00000, code: 5'd0,  valid: 1'b0, err: 1'b0};
      vecs[22] = '{dec: 20'h00003, code: 5'd0,  valid: 1'b0, err: 1'b1};
      vecs[23] = '{dec: 20'h80001, code: 5'd0,  valid: 1'b0, err: 1'b1};

      // Reset with random activity on the inputs
      Reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         WRDec_in  = 20'($urandom);
         Wr_en     = 1'($urandom);
         Bus_in    = 16'($urandom);
         Trc_ready = 1'($urandom);
         Ovf_clr   = 1'($urandom);
         tick();
      end
      chk("rst_enc_valid", Enc_valid, 0);
      chk("rst_enc_code",  Enc_code,  0);
      chk("rst_enc_err",   Enc_err,   0);
      chk("rst_trc_valid", Trc_valid, 0);
      chk("rst_trc_count", Trc_count, 0);
      chk("rst_trc_code",  Trc_code,  0);
      chk("rst_trc_data",  Trc_data,  0);
      chk("rst_trc_ovf",   Trc_ovf,   0);
      chk("rst_err_count", Err_count, 0);
      WRDec_in = '0; Wr_en = 0; Bus_in = '0; Trc_ready = 0; Ovf_clr = 0;
      Reset_n = 1'b1;
      tick();

      // Encode map sweep with Wr_en low
      for (int i = 0; i < 24; i++) begin
         WRDec_in = vecs[i].dec;
         Bus_in   = 16'(i);
         tick();
         chk($sformatf("enc_code[%0d]", i),  Enc_code,  vecs[i].code);
         chk($sformatf("enc_valid[%0d]", i), Enc_valid, vecs[i].valid);
         chk($sformatf("enc_err[%0d]", i),   Enc_err,   vecs[i].err);
         chk($sformatf("sweep_count[%0d]", i), Trc_count, 0);
      end

      // Illegal pattern qualified for 3 cycles
      WRDec_in = 20'h00003;
      Wr_en    = 1'b1;
      for (int c = 0; c < 3; c++) tick();
`ifdef WRENC_ERRCNT_EN
      exp_err = 8'd3;
`else
      exp_err = 8'd0;
`endif
      chk("illegal_err",    Enc_err,   1);
      chk("illegal_code",   Enc_code,  0);
      chk("illegal_count",  Trc_count, 0);
      chk("illegal_errcnt", Err_count, exp_err);
      Wr_en = 1'b0; WRDec_in = '0; Ovf_clr = 1'b1;
      tick();
      Ovf_clr = 1'b0;
      chk("errcnt_clear", Err_count, 0);

      // Counter saturation
      WRDec_in = 20'h00005;
      Wr_en    = 1'b1;
      for (int c = 0; c < 300; c++) tick();
`ifdef WRENC_ERRCNT_EN
      exp_err = '1;
`else
      exp_err = '0;
`endif
      chk("errcnt_sat", Err_count, exp_err);
      Wr_en = 1'b0; WRDec_in = '0; Ovf_clr = 1'b1;
      tick();
      Ovf_clr = 1'b0;
      chk("errcnt_clear2", Err_count, 0);

      // Fill to DEPTH then overflow
      for (int i = 0; i < 4; i++) push_one(20'(1) << i, 16'hA001 + 16'(i));
      chk("fill_count", Trc_count, 4);
      chk("fill_valid", Trc_valid, 1);
      chk("fill_ovf",   Trc_ovf,   0);
      push_one(20'(1) << 4, 16'hA005);
      chk("ovf_flag",  Trc_ovf,   1);
      chk("ovf_count", Trc_count, 4);
      Trc_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_code[%0d]", i), Trc_code, 5'(i + 1));
         chk($sformatf("drain_data[%0d]", i), Trc_data, 16'hA001 + 16'(i));
         tick();
      end
      Trc_ready = 1'b0;
      chk("drain_count", Trc_count, 0);
      chk("drain_valid", Trc_valid, 0);
      chk("empty_hold_code", Trc_code, 4);
      chk("empty_hold_data", Trc_data, 16'hA004);
      chk("ovf_sticky", Trc_ovf, 1);
      Ovf_clr = 1'b1;
      tick();
      Ovf_clr = 1'b0;
      chk("ovf_clear", Trc_ovf, 0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) push_one(20'(1) << i, 16'hB001 + 16'(i));
      Trc_ready = 1'b1;
      push_one(20'h80000, 16'hBEEF);
      chk("pp_full_count", Trc_count, 4);
      chk("pp_full_ovf",   Trc_ovf,   0);
      exp_codes = '{5'd2, 5'd3, 5'd4, 5'd22};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_drain_code[%0d]", i), Trc_code, exp_codes[i]);
         tick();
      end
      chk("pp_last_data", Trc_data, 16'hBEEF);
      chk("pp_empty", Trc_count, 0);

      // Push with ready high while empty: no pop, entry lands
      push_one(20'h00010, 16'h5555);
      Trc_ready = 1'b0;
      chk("pe_count", Trc_count, 1);
      chk("pe_valid", Trc_valid, 1);
      chk("pe_code",  Trc_code,  5);
      Trc_ready = 1'b1;
      tick();
      Trc_ready = 1'b0;

      // Reset mid-drain
      push_one(20'h00001, 16'hC001);
      push_one(20'h00002, 16'hC002);
      chk("md_count", Trc_count, 2);
      Trc_ready = 1'b1;
      Reset_n   = 1'b0;
      #1;
      chk("md_rst_valid", Trc_valid, 0);
      chk("md_rst_count", Trc_count, 0);
      tick();
      Reset_n   = 1'b1;
      Trc_ready = 1'b0;
      chk("md_after_count", Trc_count, 0);
      push_one(20'h00040, 16'h7777);
      chk("md_push_valid", Trc_valid, 1);
      chk("md_push_count", Trc_count, 1);
      chk("md_push_code",  Trc_code,  7);
      chk("md_push_data",  Trc_data,  16'h7777);
      chk("md_push_ovf",   Trc_ovf,   0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
